// File: rtl/ovl_fire_collector_pkg.sv
// Shared widths and record layout helpers for the checker fire collector.
// A record is {id, time} with the timestamp in the low bits.
package ovl_fire_collector_pkg;

    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int recWidth(input int n, input int tw);
        return idWidth(n) + tw;
    endfunction

    localparam int TIME_LSB = 0;

    function automatic int idLsb(input int tw);
        return TIME_LSB + tw;
    endfunction

endpackage

// File: rtl/ovl_fire_fifo.sv
// First-word-fall-through synchronous FIFO; the head holds the last popped
// word while empty so downstream fields stay steady between records.
module ovl_fire_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] lastHead_q;
    logic             doPush;
    logic             doPop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = empty ? lastHead_q : mem_q[rdPtr_q];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            lastHead_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q    <= rdPtr_q + AW'(1);
                lastHead_q <= mem_q[rdPtr_q];
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ovl_fire_collector.sv
// Collects single-cycle checker fire pulses, timestamps them, queues {id, time}
// records for the host and accounts for fires lost to a still-pending slot.
module ovl_fire_collector
    import ovl_fire_collector_pkg::*;
#(
    parameter int N     = 8,
    parameter int TW    = 16,
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    localparam int ID_W = idWidth(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [N-1:0]    fire,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic [TW-1:0]   evt_time,
    output logic            overflow,
    input  logic            clear_overflow,
    output logic [DW-1:0]   drop_count
);
    localparam int REC_W = recWidth(N, TW);
    localparam int ID_LSB = idLsb(TW);
    localparam int CW = $clog2(N + 1);
    localparam int SW = ((DW > CW) ? DW : CW) + 1;
    localparam logic [DW-1:0] MAX_COUNT = {DW{1'b1}};

    logic [TW-1:0]    time_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     pending_d;
    logic [TW-1:0]    slotTime_q [N];
    logic             overflow_q;
    logic             overflow_d;
    logic [DW-1:0]    dropCount_q;
    logic [DW-1:0]    dropCount_d;

    logic [N-1:0]     capture;
    logic [N-1:0]     grant;
    logic [N-1:0]     drops;
    logic [ID_W-1:0]  grantId;
    logic             grantValid;
    logic             canPush;
    logic             popFire;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CW-1:0]    dropNum;
    logic [SW-1:0]    dropSum;
    logic [REC_W-1:0] pushData;
    logic [REC_W-1:0] headData;

    assign popFire = !fifoEmpty && evt_ready;
    assign canPush = !fifoFull || popFire;
    assign capture = enable ? fire : '0;

    // Fixed priority: the lowest-index pending slot wins whenever the FIFO can take it.
    always_comb begin
        grant      = '0;
        grantId    = '0;
        grantValid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i] && canPush && !grantValid) begin
                grant[i]   = 1'b1;
                grantId    = i[ID_W-1:0];
                grantValid = 1'b1;
            end
        end
    end

    // A repeat fire only counts as lost if its slot is still occupied after this edge.
    always_comb begin
        drops     = capture & pending_q & ~grant;
        pending_d = (pending_q & ~grant) | capture;
        dropNum   = '0;
        for (int i = 0; i < N; i++) begin
            dropNum = dropNum + CW'(drops[i]);
        end
        dropSum     = SW'(clear_overflow ? '0 : dropCount_q) + SW'(dropNum);
        dropCount_d = (dropSum > SW'(MAX_COUNT)) ? MAX_COUNT : dropSum[DW-1:0];
        overflow_d  = (dropNum != '0) || (overflow_q && !clear_overflow);
    end

    assign pushData = {grantId, slotTime_q[grantId]};

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q      <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
            for (int i = 0; i < N; i++) begin
                slotTime_q[i] <= '0;
            end
        end else begin
            time_q      <= time_q + TW'(1);
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
            for (int i = 0; i < N; i++) begin
                if (capture[i] && !drops[i]) begin
                    slotTime_q[i] <= time_q;
                end
            end
        end
    end

    ovl_fire_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grantValid),
        .push_data (pushData),
        .pop       (evt_ready),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .head      (headData)
    );

    assign evt_valid  = !fifoEmpty;
    assign evt_id     = headData[ID_LSB +: ID_W];
    assign evt_time   = headData[TIME_LSB +: TW];
    assign overflow   = overflow_q;
    assign drop_count = dropCount_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Scenario bench for the fire collector: expected records are queued as fires
// are driven and compared as the DUT hands them over.
module tb_ovl_fire_collector;

    typedef struct {
        logic [2:0]  id;
        logic [15:0] t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [7:0]  fire = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [2:0]  evt_id;
    logic [15:0] evt_time;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [7:0]  drop_count;

    int          vecCount = 0;
    int          missCount = 0;
    logic [15:0] tbTime = '0;
    rec_t        expQ[$];
    rec_t        r;

    ovl_fire_collector #(.N(8), .TW(16), .DEPTH(8), .DW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fire           (fire),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_id         (evt_id),
        .evt_time       (evt_time),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic stepCycle();
        @(posedge clk);
        tbTime = rst ? 16'd0 : tbTime + 16'd1;
        #1;
    endtask

    task automatic pushFires(input logic [7:0] vec);
        for (int i = 0; i < 8; i++) begin
            if (vec[i]) begin
                r.id = 3'(i);
                r.t  = tbTime;
                expQ.push_back(r);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        vecCount++;
        if (evt_valid !== 1'b0 || evt_id !== 3'd0 || evt_time !== 16'd0) begin
            missCount++;
            $display("[TB] FAIL reset_outputs valid=%0b id=%0d time=%0d, required 0/0/0", evt_valid, evt_id, evt_time);
        end
        vecCount++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            missCount++;
            $display("[TB] FAIL reset_drop overflow=%0b drops=%0d, required 0/0", overflow, drop_count);
        end
    endtask

    task automatic test_single_fire();
        evt_ready = 1'b1;
        while (tbTime != 16'd5) stepCycle();
        fire = 8'b0000_1000;
        pushFires(fire);
        stepCycle();
        fire = '0;
        vecCount++;
        if (evt_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL single_early valid=%0b, required 0", evt_valid);
        end
        stepCycle();
        vecCount++;
        r = expQ.pop_front();
        if (evt_valid !== 1'b1 || evt_id !== r.id || evt_time !== r.t) begin
            missCount++;
            $display("[TB] FAIL single_record valid=%0b id=%0d time=%0d, required 1/%0d/%0d", evt_valid, evt_id, evt_time, r.id, r.t);
        end
        stepCycle();
        vecCount++;
        if (evt_valid !== 1'b0 || evt_id !== 3'd3 || evt_time !== 16'd5) begin
            missCount++;
            $display("[TB] FAIL single_after valid=%0b id=%0d time=%0d, required 0/3/5 held", evt_valid, evt_id, evt_time);
        end
    endtask

    task automatic test_coalesce();
        evt_ready = 1'b1;
        while (tbTime != 16'd20) stepCycle();
        fire = 8'b1010_0001;
        pushFires(fire);
        stepCycle();
        fire = '0;
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            vecCount++;
            r = expQ.pop_front();
            if (evt_valid !== 1'b1 || evt_id !== r.id || evt_time !== r.t) begin
                missCount++;
                $display("[TB] FAIL coalesce_rec%0d valid=%0b id=%0d time=%0d, required 1/%0d/%0d", k, evt_valid, evt_id, evt_time, r.id, r.t);
            end
            stepCycle();
        end
        vecCount++;
        if (evt_valid !== 1'b0 || overflow !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL coalesce_end valid=%0b overflow=%0b, required 0/0", evt_valid, overflow);
        end
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fire = 8'(1 << i);
            pushFires(fire);
            stepCycle();
        end
        fire = 8'b0000_0001;
        pushFires(fire);
        stepCycle();
        fire = '0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            vecCount++;
            if (evt_valid !== 1'b1 || evt_id !== expQ[0].id || evt_time !== expQ[0].t) begin
                missCount++;
                $display("[TB] FAIL bp_stable%0d valid=%0b id=%0d time=%0d, required 1/%0d/%0d", k, evt_valid, evt_id, evt_time, expQ[0].id, expQ[0].t);
            end
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
            if (evt_valid) begin
                r = expQ.pop_front();
                vecCount++;
                if (evt_id !== r.id || evt_time !== r.t) begin
                    missCount++;
                    $display("[TB] FAIL bp_drain id=%0d time=%0d, required %0d/%0d", evt_id, evt_time, r.id, r.t);
                end
            end
            stepCycle();
        end
        vecCount++;
        if (expQ.size() != 0 || evt_valid !== 1'b0 || drop_count !== 8'd0) begin
            missCount++;
            $display("[TB] FAIL bp_end left=%0d valid=%0b drops=%0d, required 0/0/0", expQ.size(), evt_valid, drop_count);
            expQ.delete();
        end
    endtask

    task automatic test_drops();
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fire = 8'(1 << i);
            pushFires(fire);
            stepCycle();
        end
        fire = 8'b0000_0100;
        pushFires(fire);
        stepCycle();
        for (int k = 0; k < 3; k++) begin
            fire = 8'b0000_0100;
            stepCycle();
            fire = '0;
            stepCycle();
        end
        vecCount++;
        if (drop_count !== 8'd3 || overflow !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL drop_count3 drops=%0d overflow=%0b, required 3/1", drop_count, overflow);
        end
        clear_overflow = 1'b1;
        fire = 8'b0000_0100;
        stepCycle();
        clear_overflow = 1'b0;
        fire = '0;
        vecCount++;
        if (drop_count !== 8'd1 || overflow !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL drop_clear_race drops=%0d overflow=%0b, required 1/1", drop_count, overflow);
        end
        clear_overflow = 1'b1;
        stepCycle();
        clear_overflow = 1'b0;
        vecCount++;
        if (drop_count !== 8'd0 || overflow !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL drop_clear drops=%0d overflow=%0b, required 0/0", drop_count, overflow);
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
            if (evt_valid) begin
                r = expQ.pop_front();
                vecCount++;
                if (evt_id !== r.id || evt_time !== r.t) begin
                    missCount++;
                    $display("[TB] FAIL drop_drain id=%0d time=%0d, required %0d/%0d", evt_id, evt_time, r.id, r.t);
                end
            end
            stepCycle();
        end
        vecCount++;
        if (expQ.size() != 0 || evt_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL drop_end left=%0d valid=%0b, required 0/0", expQ.size(), evt_valid);
            expQ.delete();
        end
    endtask

    task automatic test_disable();
        enable = 1'b1;
        evt_ready = 1'b0;
        fire = 8'b0101_0000;
        pushFires(fire);
        stepCycle();
        fire = '0;
        stepCycle();
        stepCycle();
        enable = 1'b0;
        evt_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            fire = 8'($urandom);
            if (evt_valid) begin
                vecCount++;
                if (expQ.size() == 0) begin
                    missCount++;
                    $display("[TB] FAIL disable_extra id=%0d time=%0d, required no record", evt_id, evt_time);
                end else begin
                    r = expQ.pop_front();
                    if (evt_id !== r.id || evt_time !== r.t) begin
                        missCount++;
                        $display("[TB] FAIL disable_drain id=%0d time=%0d, required %0d/%0d", evt_id, evt_time, r.id, r.t);
                    end
                end
            end
            stepCycle();
        end
        fire = '0;
        stepCycle();
        stepCycle();
        enable = 1'b1;
        vecCount++;
        if (expQ.size() != 0 || evt_valid !== 1'b0 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL disable_end left=%0d valid=%0b drops=%0d overflow=%0b, required 0/0/0/0", expQ.size(), evt_valid, drop_count, overflow);
            expQ.delete();
        end
    endtask

    task automatic test_mid_reset();
        evt_ready = 1'b0;
        fire = 8'b0011_1111;
        stepCycle();
        fire = '0;
        for (int k = 0; k < 4; k++) stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        expQ.delete();
        vecCount++;
        if (evt_valid !== 1'b0 || evt_id !== 3'd0 || evt_time !== 16'd0) begin
            missCount++;
            $display("[TB] FAIL rst_mid valid=%0b id=%0d time=%0d, required 0/0/0", evt_valid, evt_id, evt_time);
        end
        evt_ready = 1'b1;
        fire = 8'b0000_0010;
        pushFires(fire);
        stepCycle();
        fire = '0;
        vecCount++;
        if (evt_valid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rst_stale valid=%0b id=%0d, required 0", evt_valid, evt_id);
        end
        stepCycle();
        vecCount++;
        r = expQ.pop_front();
        if (evt_valid !== 1'b1 || evt_id !== r.id || evt_time !== r.t) begin
            missCount++;
            $display("[TB] FAIL rst_timebase valid=%0b id=%0d time=%0d, required 1/%0d/%0d", evt_valid, evt_id, evt_time, r.id, r.t);
        end
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            vecCount++;
            if (evt_valid !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL rst_quiet%0d valid=%0b id=%0d, required 0", k, evt_valid, evt_id);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_coalesce();
        test_backpressure();
        test_drops();
        test_disable();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
